pattern_test_sequencer: RTL and testbench

Autonomous stimulus controller for the serial shift register and pattern-detector FSMs on the DE0-CV counter/shift/FSM exercise. On a start command it captures a parallel pattern and replays it bit-serially into the shift register's `in`/`enable` pins a programmable number of times. It then holds the shifter idle for a flush window and counts cycles in which the detector output is high. It replaces manual KEY-driven shifting and sits between the switch/key inputs and the shift register + detector pair, all on the divided global clock.

---
 rtl/pattern_test_sequencer_if.sv | 31 +++
 rtl/pattern_test_sequencer.sv | 140 ++++++++++++++
 tb/tb_pattern_test_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_test_sequencer_if.sv
`default_nettype none
// ------------------------------------------------------------------
// pattern_test_sequencer_if: control, pattern and result bundle for the sequencer
// Rev 1.0
// ------------------------------------------------------------------
interface pattern_test_sequencer_if #(
  parameter int PATTERN_W = 10,
  parameter int COUNT_W   = 8
);
  logic                 start;
  logic                 abort;
  logic [PATTERN_W-1:0] pattern;
  logic [3:0]           repeat_n;
  logic                 detect;
  logic                 shift_in;
  logic                 shift_enable;
  logic                 busy;
  logic                 done;
  logic [COUNT_W-1:0]   hit_count;

  modport master (
    output start, abort, pattern, repeat_n, detect,
    input  shift_in, shift_enable, busy, done, hit_count
  );

  modport slave (
    input  start, abort, pattern, repeat_n, detect,
    output shift_in, shift_enable, busy, done, hit_count
  );
endinterface
`default_nettype wire

// File: rtl/pattern_test_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// pattern_test_sequencer: replays a pattern bit-serially N times, then counts detector hits
// Macro PATTERN_TEST_SEQUENCER_MSB_FIRST_EN sends bit PATTERN_W-1 first.  Rev 1.0
// ------------------------------------------------------------------
module pattern_test_sequencer #(
  parameter int PATTERN_W    = 10,
  parameter int COUNT_W      = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  pattern_test_sequencer_if.slave bus
);

  localparam int BIT_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [PATTERN_W-1:0] pat_reg;
  logic [PATTERN_W-1:0] shadow;
  logic [PATTERN_W-1:0] shadow_next;
  logic [BIT_W-1:0]     bit_cnt;
  logic [3:0]           passes_left;
  logic [3:0]           flush_cnt;
  logic [COUNT_W-1:0]   hit_count;
  logic                 shift_bit;
  logic                 last_bit;
  logic                 flush_end;
  logic                 active;

  assign last_bit  = (bit_cnt == BIT_W'(PATTERN_W - 1));
  assign flush_end = (flush_cnt == 4'(FLUSH_CYCLES - 1));
  assign active    = (state == S_LOAD) || (state == S_SHIFT) || (state == S_FLUSH);

`ifdef PATTERN_TEST_SEQUENCER_MSB_FIRST_EN
  assign shadow_next = {shadow[PATTERN_W-2:0], 1'b0};
  assign shift_bit   = shadow[PATTERN_W-1];
`else
  assign shadow_next = {1'b0, shadow[PATTERN_W-1:1]};
  assign shift_bit   = shadow[0];
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs depend on state/shadow registers only, never on inputs.
  always_comb begin
    state_next       = state;
    bus.shift_enable = 1'b0;
    bus.shift_in     = 1'b0;
    bus.busy         = (state != S_IDLE);
    bus.done         = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_next = (bus.repeat_n != 4'd0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: state_next = S_SHIFT;
      S_SHIFT: begin
        bus.shift_enable = 1'b1;
        bus.shift_in     = shift_bit;
        if (last_bit) begin
          state_next = (passes_left > 4'd1) ? S_LOAD : S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (flush_end) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        bus.done   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (active && bus.abort) begin
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pat_reg     <= '0;
      shadow      <= '0;
      bit_cnt     <= '0;
      passes_left <= '0;
      flush_cnt   <= '0;
      hit_count   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            hit_count <= '0;
            if (bus.repeat_n != 4'd0) begin
              pat_reg     <= bus.pattern;
              passes_left <= bus.repeat_n;
            end
          end
        end
        S_LOAD: begin
          shadow  <= pat_reg;
          bit_cnt <= '0;
        end
        S_SHIFT: begin
          shadow    <= shadow_next;
          bit_cnt   <= bit_cnt + 1'b1;
          flush_cnt <= '0;
          if (last_bit && (passes_left > 4'd1)) begin
            passes_left <= passes_left - 4'd1;
          end
        end
        S_FLUSH: flush_cnt <= flush_cnt + 4'd1;
        default: ;
      endcase
      if (active && bus.detect && (hit_count != {COUNT_W{1'b1}})) begin
        hit_count <= hit_count + 1'b1;
      end
    end
  end

  assign bus.hit_count = hit_count;

endmodule
`default_nettype wire

// File: tb/tb_pattern_test_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_pattern_test_sequencer: scoreboard bench, two DUTs (8-bit and 3-bit hit counters)
// Rev 1.0
// ------------------------------------------------------------------
module tb_pattern_test_sequencer;

  localparam int W     = 10;
  localparam int FL    = 2;
  localparam int SAT_A = 255;
  localparam int SAT_B = 7;

  typedef struct { int cyc; logic b; } bit_exp_t;
  typedef struct { int cyc; int hits; } res_exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  bit_exp_t bitq[$];
  res_exp_t resq[$];
  res_exp_t resqb[$];
  bit_exp_t eb;
  res_exp_t er;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pattern_test_sequencer_if #(.PATTERN_W(W), .COUNT_W(8)) ifa ();
  pattern_test_sequencer_if #(.PATTERN_W(W), .COUNT_W(3)) ifb ();

  assign ifb.start    = ifa.start;
  assign ifb.abort    = ifa.abort;
  assign ifb.pattern  = ifa.pattern;
  assign ifb.repeat_n = ifa.repeat_n;
  assign ifb.detect   = ifa.detect;

  pattern_test_sequencer #(.PATTERN_W(W), .COUNT_W(8), .FLUSH_CYCLES(FL)) dut_a (
    .clock(clk), .reset_n(reset_n), .bus(ifa)
  );
  pattern_test_sequencer #(.PATTERN_W(W), .COUNT_W(3), .FLUSH_CYCLES(FL)) dut_b (
    .clock(clk), .reset_n(reset_n), .bus(ifb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // b-th bit to leave the sequencer within one pass
  function automatic logic send_bit(input logic [W-1:0] pat, input int b);
`ifdef PATTERN_TEST_SEQUENCER_MSB_FIRST_EN
    return pat[W-1-b];
`else
    return pat[b];
`endif
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (ifa.shift_enable === 1'b1) begin
        if (bitq.size() == 0) begin
          check("unexpected_shift", 32'd1, 32'd0);
        end else begin
          eb = bitq.pop_front();
          check("shift_cycle", cyc, eb.cyc);
          check("shift_in", {31'd0, ifa.shift_in}, {31'd0, eb.b});
        end
      end else begin
        check("shift_in_idle", {31'd0, ifa.shift_in}, 32'd0);
      end
      if (ifa.done === 1'b1) begin
        if (resq.size() == 0) begin
          check("unexpected_done_a", 32'd1, 32'd0);
        end else begin
          er = resq.pop_front();
          check("done_cycle_a", cyc, er.cyc);
          check("hit_count_a", {24'd0, ifa.hit_count}, er.hits);
        end
      end
      if (ifb.done === 1'b1) begin
        if (resqb.size() == 0) begin
          check("unexpected_done_b", 32'd1, 32'd0);
        end else begin
          er = resqb.pop_front();
          check("done_cycle_b", cyc, er.cyc);
          check("hit_count_b", {29'd0, ifb.hit_count}, er.hits);
        end
      end
    end
  end

  // det_pct < 0 selects detect high in cycles 3..5 only; extra_at < 0 means start during DONE
  task automatic run(input logic [W-1:0] pat, input int reps, input int abort_at,
                     input int det_pct, input int extra_at);
    int   c0, done_rel, last, hits, xs, rel;
    logic d;
    done_rel = (reps == 0) ? 1 : reps * (1 + W) + FL + 1;
    last     = (abort_at > 0) ? abort_at : done_rel;
    xs       = (extra_at < 0) ? done_rel : extra_at;
    hits     = 0;
    @(posedge clk); #1;
    c0           = cyc;
    ifa.start    = 1'b1;
    ifa.pattern  = pat;
    ifa.repeat_n = 4'(reps);
    ifa.abort    = 1'b0;
    ifa.detect   = 1'($urandom_range(0, 1));
    for (int p = 0; p < reps; p++) begin
      for (int b = 0; b < W; b++) begin
        rel = 2 + p * (1 + W) + b;
        if (abort_at == 0 || rel <= abort_at) bitq.push_back('{c0 + rel, send_bit(pat, b)});
      end
    end
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      ifa.start    = (k == xs);
      ifa.pattern  = W'($urandom);
      ifa.repeat_n = 4'($urandom);
      ifa.abort    = (k == abort_at);
      if (det_pct < 0) d = (k >= 3 && k <= 5);
      else             d = ($urandom_range(1, 100) <= det_pct);
      if (k == abort_at) d = 1'b0;
      ifa.detect = d;
      if (k < done_rel && d) hits++;
      if (k == done_rel && abort_at == 0) begin
        resq.push_back('{c0 + done_rel, sat(hits, SAT_A)});
        resqb.push_back('{c0 + done_rel, sat(hits, SAT_B)});
      end
      @(negedge clk);
      check("busy_run", {31'd0, ifa.busy}, 32'd1);
    end
    @(posedge clk); #1;
    ifa.start  = 1'b0;
    ifa.abort  = 1'b0;
    ifa.detect = 1'b0;
    @(negedge clk);
    check("busy_after", {31'd0, ifa.busy}, 32'd0);
    check("enable_after", {31'd0, ifa.shift_enable}, 32'd0);
    if (abort_at > 0) begin
      check("hit_abort_a", {24'd0, ifa.hit_count}, sat(hits, SAT_A));
      check("hit_abort_b", {29'd0, ifb.hit_count}, sat(hits, SAT_B));
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, {31'd0, ifa.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, ifa.done}, 32'd0);
    check({tag, "_en"}, {31'd0, ifa.shift_enable}, 32'd0);
    check({tag, "_in"}, {31'd0, ifa.shift_in}, 32'd0);
    check({tag, "_hit_a"}, {24'd0, ifa.hit_count}, 32'd0);
    check({tag, "_hit_b"}, {29'd0, ifb.hit_count}, 32'd0);
  endtask

  initial begin
    int reps, ab, done_rel;
    ifa.start    = 1'b1;
    ifa.abort    = 1'b0;
    ifa.pattern  = '0;
    ifa.repeat_n = 4'd1;
    ifa.detect   = 1'b1;
    reset_n      = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_idle("reset");
    end
    reset_n    = 1'b1;
    ifa.start  = 1'b0;
    ifa.detect = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle("release");
    mon_en = 1'b1;

    run(10'h2A5, 1, 0, 0, 0);
    run(W'($urandom), 3, 0, 25, 20);
    run(W'($urandom), 2, 0, 100, 0);
    run(W'($urandom), 1, 0, 0, 0);
    run(W'($urandom), 1, 6, -1, 0);
    run(W'($urandom), 0, 0, 50, 1);

    for (int i = 0; i < 12; i++) begin
      reps     = $urandom_range(0, 4);
      done_rel = (reps == 0) ? 1 : reps * (1 + W) + FL + 1;
      ab       = 0;
      if (reps > 0 && $urandom_range(0, 2) == 0) ab = $urandom_range(1, done_rel - 1);
      run(W'($urandom), reps, ab, 30, (ab == 0 && $urandom_range(0, 1) == 1) ? -1 : 0);
    end

    mon_en = 1'b0;
    @(posedge clk); #1;
    ifa.start    = 1'b1;
    ifa.repeat_n = 4'd2;
    ifa.pattern  = W'($urandom);
    ifa.detect   = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      ifa.start = 1'b0;
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n    = 1'b1;
    ifa.detect = 1'b0;
    @(negedge clk);
    check_idle("midrun_reset");
    mon_en = 1'b1;
    repeat (3) @(posedge clk);

    check("bitq_empty", bitq.size(), 32'd0);
    check("resq_empty", resq.size(), 32'd0);
    check("resqb_empty", resqb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
